// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its reader/writer sides,
// plus the reference result calculation both sides agree on.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] operand_res;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t    opc;
    operand_t   op_a;
    operand_t   op_b;
    operand_res rezultat;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } reader_state_t;

  // Operands are widened before the arithmetic so MULT cannot overflow.
  function automatic operand_res calc_result(input opcode_t opc, input operand_t a,
                                             input operand_t b);
    operand_res wa;
    operand_res wb;
    operand_res res;
    wa  = a;
    wb  = b;
    res = '0;
    case (opc)
      ZERO:    res = '0;
      PASSA:   res = wa;
      PASSB:   res = wb;
      ADD:     res = wa + wb;
      SUB:     res = wa - wb;
      MULT:    res = wa * wb;
      DIV:     res = (wb == 64'sd0) ? '0 : wa / wb;
      MOD:     res = (wb == 64'sd0) ? '0 : wa % wb;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/instr_reader_checker.sv
// Combinational check of one entry: flags a stored result that disagrees
// with the recomputed one.
module instr_checker
  import instr_register_pkg::*;
(
  input  instruction_t instr,
  output logic         mismatch
);

  always_comb begin
    mismatch = (calc_result(instr.opc, instr.op_a, instr.op_b) != instr.rezultat);
  end

endmodule

// File: rtl/instr_reader.sv
// Read-side sequencer: walks a wrapping address range, hands each entry to a
// valid/ready consumer and counts entries whose stored result is wrong.
module instr_reader
  import instr_register_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     first_ptr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instr,
  output address_t     out_addr,
  output logic         mismatch,
  output logic         busy,
  output logic         done,
  output logic [5:0]   err_count
);

  reader_state_t state_q, state_d;
  address_t      read_pointer_q, read_pointer_d;
  logic [5:0]    remaining_q, remaining_d;
  logic          out_valid_q, out_valid_d;
  instruction_t  out_instr_q, out_instr_d;
  address_t      out_addr_q, out_addr_d;
  logic          mismatch_q, mismatch_d;
  logic [5:0]    err_count_q, err_count_d;
  logic          raw_mismatch;
  logic          chk_mismatch;

  instr_checker u_checker (
    .instr    (instruction_word),
    .mismatch (raw_mismatch)
  );

  always_comb begin
    chk_mismatch   = CHECK_EN ? raw_mismatch : 1'b0;
    state_d        = state_q;
    read_pointer_d = read_pointer_q;
    remaining_d    = remaining_q;
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_addr_d     = out_addr_q;
    mismatch_d     = mismatch_q;
    err_count_d    = err_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_count_d = '0;
          if (count != 6'd0) begin
            read_pointer_d = first_ptr;
            remaining_d    = count;
            state_d        = READ;
          end else begin
            state_d = FIN;
          end
        end
      end
      READ: begin
        // A capture also retires the previous beat when the consumer is ready.
        if (!out_valid_q || out_ready) begin
          out_instr_d    = instruction_word;
          out_addr_d     = read_pointer_q;
          out_valid_d    = 1'b1;
          mismatch_d     = chk_mismatch;
          err_count_d    = err_count_q + {5'd0, chk_mismatch};
          read_pointer_d = read_pointer_q + 5'd1;
          remaining_d    = remaining_q - 6'd1;
          if (remaining_q == 6'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      read_pointer_q <= '0;
      remaining_q    <= '0;
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_addr_q     <= '0;
      mismatch_q     <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      read_pointer_q <= read_pointer_d;
      remaining_q    <= remaining_d;
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_addr_q     <= out_addr_d;
      mismatch_q     <= mismatch_d;
      err_count_q    <= err_count_d;
    end
  end

  assign read_pointer = read_pointer_q;
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_addr     = out_addr_q;
  assign mismatch     = mismatch_q;
  assign err_count    = err_count_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);

endmodule

// File: tb/tb_instr_reader.sv
// Directed bench for instr_reader: bursts, wrap, backpressure, result
// checking with and without CHECK_EN, edge commands and async reset.
module tb_instr_reader;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  address_t     first_ptr;
  logic [5:0]   count;
  logic         out_ready;

  address_t     read_pointer, read_pointer_nc;
  instruction_t instruction_word, instruction_word_nc;
  logic         out_valid, out_valid_nc;
  instruction_t out_instr, out_instr_nc;
  address_t     out_addr, out_addr_nc;
  logic         mismatch, mismatch_nc;
  logic         busy, busy_nc;
  logic         done, done_nc;
  logic [5:0]   err_count, err_count_nc;

  instruction_t mem [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instruction_word    = mem[read_pointer];
  assign instruction_word_nc = mem[read_pointer_nc];

  instr_reader #(.CHECK_EN(1'b1)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_ptr        (first_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_addr         (out_addr),
    .mismatch         (mismatch),
    .busy             (busy),
    .done             (done),
    .err_count        (err_count)
  );

  instr_reader #(.CHECK_EN(1'b0)) dut_nochk (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .first_ptr        (first_ptr),
    .count            (count),
    .read_pointer     (read_pointer_nc),
    .instruction_word (instruction_word_nc),
    .out_valid        (out_valid_nc),
    .out_ready        (out_ready),
    .out_instr        (out_instr_nc),
    .out_addr         (out_addr_nc),
    .mismatch         (mismatch_nc),
    .busy             (busy_nc),
    .done             (done_nc),
    .err_count        (err_count_nc)
  );

  function automatic instruction_t mk(input opcode_t opc, input int a, input int b,
                                      input longint res);
    instruction_t t;
    t.opc      = opc;
    t.op_a     = a;
    t.op_b     = b;
    t.rezultat = res;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [135:0] actual,
                             input logic [135:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input address_t fp, input logic [5:0] cnt);
    first_ptr = fp;
    count     = cnt;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic expectBeat(input string tag, input address_t addr, input logic mm);
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_addr"}, out_addr, addr);
    checkOutput({tag, "_instr"}, out_instr, mem[addr]);
    checkOutput({tag, "_mm"}, mismatch, mm);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    address_t wrap_addr [4];
    wrap_addr = '{5'd30, 5'd31, 5'd0, 5'd1};

    for (int i = 0; i < 32; i++) mem[i] = mk(PASSB, i, 2 * i, 2 * i);
    mem[0]  = mk(ADD, 5, 3, 8);
    mem[1]  = mk(SUB, 2, 7, -5);
    mem[2]  = mk(MULT, -4, 6, -24);
    mem[3]  = mk(DIV, 9, 0, 0);
    mem[4]  = mk(ZERO, 7, 7, 0);
    mem[5]  = mk(ADD, 1, 1, 3);
    mem[6]  = mk(opcode_t'(4'd12), 4, 4, 0);
    mem[7]  = mk(opcode_t'(4'd13), 4, 4, 5);
    mem[8]  = mk(MOD, 6, 0, 0);
    mem[30] = mk(PASSA, 11, 22, 11);
    mem[31] = mk(MOD, 17, 5, 2);

    reset_n   = 1'b0;
    start     = 1'b0;
    first_ptr = '0;
    count     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_rp", read_pointer, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_instr", out_instr, 0);
    checkOutput("rst_addr", out_addr, 0);
    checkOutput("rst_mm", mismatch, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err_count, 0);
    reset_n = 1'b1;
    tick();

    // Basic four-entry burst with out_ready held high.
    applyStimulus(5'd0, 6'd4);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_nolat", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expectBeat($sformatf("t1_b%0d", i), address_t'(i), 1'b0);
    end
    tick();
    checkOutput("t1_valid_end", out_valid, 0);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_err", err_count, 0);
    tick();
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_idle", busy, 0);
    checkOutput("t1_rp", read_pointer, 4);

    // Address wrap 30, 31, 0, 1.
    applyStimulus(5'd30, 6'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      expectBeat($sformatf("t2_b%0d", i), wrap_addr[i], 1'b0);
    end
    tick();
    checkOutput("t2_done", done, 1);
    tick();
    checkOutput("t2_rp", read_pointer, 2);
    checkOutput("t2_idle", busy, 0);

    // Backpressure after the first beat, with a start that must be ignored.
    applyStimulus(5'd0, 6'd3);
    tick();
    expectBeat("t3_b0", 5'd0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        first_ptr = 5'd20;
        count     = 6'd5;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      expectBeat($sformatf("t3_hold%0d", i), 5'd0, 1'b0);
      checkOutput($sformatf("t3_rp_hold%0d", i), read_pointer, 1);
    end
    out_ready = 1'b1;
    tick();
    expectBeat("t3_b1", 5'd1, 1'b0);
    tick();
    expectBeat("t3_b2", 5'd2, 1'b0);
    tick();
    checkOutput("t3_done", done, 1);
    checkOutput("t3_valid_end", out_valid, 0);
    tick();
    checkOutput("t3_no_restart", busy, 0);
    tick();
    checkOutput("t3_still_idle", busy, 0);
    checkOutput("t3_rp", read_pointer, 3);

    // Corrupt entry 5, checked and unchecked instances side by side.
    applyStimulus(5'd5, 6'd1);
    tick();
    expectBeat("t4_b0", 5'd5, 1'b1);
    checkOutput("t4_err", err_count, 1);
    checkOutput("t4_nc_valid", out_valid_nc, 1);
    checkOutput("t4_nc_addr", out_addr_nc, 5);
    checkOutput("t4_nc_instr", out_instr_nc, mem[5]);
    checkOutput("t4_nc_mm", mismatch_nc, 0);
    checkOutput("t4_nc_err", err_count_nc, 0);
    tick();
    checkOutput("t4_done", done, 1);
    checkOutput("t4_nc_done", done_nc, 1);
    checkOutput("t4_err_hold", err_count, 1);
    tick();
    checkOutput("t4_nc_busy", busy_nc, 0);
    checkOutput("t4_nc_rp", read_pointer_nc, 6);

    // Undefined opcodes expect 0; MOD by zero expects 0.
    applyStimulus(5'd6, 6'd3);
    checkOutput("t5_err_clr", err_count, 0);
    tick();
    expectBeat("t5_b0", 5'd6, 1'b0);
    tick();
    expectBeat("t5_b1", 5'd7, 1'b1);
    tick();
    expectBeat("t5_b2", 5'd8, 1'b0);
    checkOutput("t5_err", err_count, 1);
    tick();
    tick();

    // count = 0: done without any data, err_count cleared.
    applyStimulus(5'd9, 6'd0);
    checkOutput("t6_done", done, 1);
    checkOutput("t6_busy", busy, 1);
    checkOutput("t6_valid", out_valid, 0);
    checkOutput("t6_err", err_count, 0);
    tick();
    checkOutput("t6_done_pulse", done, 0);
    checkOutput("t6_idle", busy, 0);
    checkOutput("t6_valid2", out_valid, 0);
    checkOutput("t6_rp", read_pointer, 9);

    // Async reset mid-burst, then a fresh command.
    applyStimulus(5'd4, 6'd4);
    tick();
    tick();
    expectBeat("t7_b1", 5'd5, 1'b1);
    reset_n = 1'b0;
    #2;
    checkOutput("t7_rst_valid", out_valid, 0);
    checkOutput("t7_rst_rp", read_pointer, 0);
    checkOutput("t7_rst_addr", out_addr, 0);
    checkOutput("t7_rst_instr", out_instr, 0);
    checkOutput("t7_rst_mm", mismatch, 0);
    checkOutput("t7_rst_busy", busy, 0);
    checkOutput("t7_rst_done", done, 0);
    checkOutput("t7_rst_err", err_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    applyStimulus(5'd2, 6'd2);
    tick();
    expectBeat("t7_b0", 5'd2, 1'b0);
    tick();
    expectBeat("t7_b1b", 5'd3, 1'b0);
    tick();
    checkOutput("t7_done", done, 1);
    tick();
    checkOutput("t7_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
